awgn_seq_ctrl: RTL and testbench

Sequencer and output buffer for the Box-Muller AWGN generator. It holds the six URNG seeds in a register file and drives the generator's reset and seed inputs. It walks the generator through seed load and pipeline warm-up, then captures each x0/x1 pair into a FIFO. Samples leave one at a time on a valid/ready stream, and a sample-count budget or a stop request ends the run.

---
 rtl/awgn_pkg.sv | 40 ++++
 rtl/awgn_pair_fifo.sv | 68 ++++++
 rtl/awgn_seq_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_awgn_seq_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/awgn_pkg.sv
// Shared definitions for the AWGN sequencer slice.
//   - awgn_state_e : sequencer states (IDLE, SEED, WARM, RUN, DRAIN)
//   - ADDR_*       : config address map (7 is reserved, writes to it are dropped)
//   - default_seed : power-on URNG seed values
//   - SEED_MIN     : smallest seed value the URNGs accept
//   - SAMPLE_W     : generator sample width
package awgn_pkg;

  localparam int SAMPLE_W  = 16;
  localparam int SEED_W    = 32;
  localparam int NUM_SEEDS = 6;

  localparam logic [SEED_W-1:0] SEED_MIN = 32'd16;

  localparam logic [2:0] ADDR_SEED1  = 3'd0;
  localparam logic [2:0] ADDR_SEED6  = 3'd5;
  localparam logic [2:0] ADDR_BUDGET = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEED  = 3'd1,
    ST_WARM  = 3'd2,
    ST_RUN   = 3'd3,
    ST_DRAIN = 3'd4
  } awgn_state_e;

  function automatic logic [SEED_W-1:0] default_seed(input int idx);
    logic [SEED_W-1:0] s;
    case (idx)
      0:       s = 32'h0000_1234;
      1:       s = 32'h0000_5678;
      2:       s = 32'h0009_ABCD;
      3:       s = 32'h0000_4321;
      4:       s = 32'h0000_8765;
      default: s = 32'h000D_CBA9;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/awgn_pair_fifo.sv
// Two-write / one-read FIFO holding DEPTH samples.
//   clk, reset      : clock, async active-low reset
//   flush           : empties the FIFO (pointers and count to zero)
//   push            : write wdata0 then wdata1 (wdata0 is read out first)
//   pop             : consume the head entry
//   rdata           : head entry (valid when !empty)
//   full2           : fewer than two entries free; a push is dropped
//   empty           : no entries stored
// DEPTH must be an even power of two, at least 4, so a pair never straddles
// a partially valid slot and pointers wrap naturally.
module awgn_pair_fifo
  import awgn_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                push,
  input  logic [SAMPLE_W-1:0] wdata0,
  input  logic [SAMPLE_W-1:0] wdata1,
  input  logic                pop,
  output logic [SAMPLE_W-1:0] rdata,
  output logic                full2,
  output logic                empty
);

  localparam int AW = $clog2(DEPTH);

  logic [SAMPLE_W-1:0] mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW:0]         count;
  logic                do_push;
  logic                do_pop;

  // Free-space check is on occupancy before any pop in the same cycle.
  assign full2   = count > (AW+1)'(DEPTH - 2);
  assign empty   = (count == '0);
  assign do_push = push && !full2 && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(2);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (do_push ? (AW+1)'(2) : '0) - (do_pop ? (AW+1)'(1) : '0);
    end
  end

  // Storage needs no reset: the count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr]           <= wdata0;
      mem[wr_ptr + AW'(1)]  <= wdata1;
    end
  end

endmodule

// File: rtl/awgn_seq_ctrl.sv
// Sequencer and output buffer for the Box-Muller AWGN generator.
//   clk, reset            : clock, async active-low reset
//   cfg_we/addr/wdata     : config writes (IDLE only); 0..5 seeds, 6 budget
//   start, stop           : run control pulses
//   busy                  : not IDLE
//   cfg_err               : sticky, a seed write below SEED_MIN was rejected
//   gen_reset             : hold for the generator (low only in WARM and RUN)
//   seed1..seed6          : seed registers to the generator
//   gen_x0, gen_x1        : generator sample pair
//   out_data/valid/ready  : sample stream; valid/ready handshake below
//   drop_cnt              : saturating count of pairs lost to a full FIFO
//   state_dbg             : current sequencer state (awgn_state_e encoding)
// Handshake: a sample transfers on a rising edge where out_valid && out_ready;
// while out_valid && !out_ready, out_data and out_valid hold.
module awgn_seq_ctrl
  import awgn_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int RST_CYCLES = 4,
  parameter int WARMUP     = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [2:0]          cfg_addr,
  input  logic [31:0]         cfg_wdata,
  input  logic                start,
  input  logic                stop,
  output logic                busy,
  output logic                cfg_err,
  output logic                gen_reset,
  output logic [31:0]         seed1,
  output logic [31:0]         seed2,
  output logic [31:0]         seed3,
  output logic [31:0]         seed4,
  output logic [31:0]         seed5,
  output logic [31:0]         seed6,
  input  logic [SAMPLE_W-1:0] gen_x0,
  input  logic [SAMPLE_W-1:0] gen_x1,
  output logic [SAMPLE_W-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [15:0]         drop_cnt,
  output logic [2:0]          state_dbg
);

  awgn_state_e         state_q, state_d;
  logic [7:0]          phase_cnt;
  logic [SEED_W-1:0]   seed_q [NUM_SEEDS];
  logic [31:0]         budget_q;
  logic [32:0]         remaining_q;
  logic                continuous_q;
  logic                run_start;
  logic                capture;
  logic                push;
  logic                drop;
  logic                last_pair;
  logic                cfg_wr_ok;
  logic                fifo_full2;
  logic                fifo_empty;
  logic                fifo_pop;
  logic [SAMPLE_W-1:0] fifo_rdata;

  assign busy      = (state_q != ST_IDLE);
  assign gen_reset = !(state_q == ST_WARM || state_q == ST_RUN);
  assign state_dbg = state_q;
  assign cfg_wr_ok = cfg_we && (state_q == ST_IDLE);

  assign capture   = (state_q == ST_RUN);
  assign push      = capture && !fifo_full2;
  assign drop      = capture && fifo_full2;
  // Budget runs end on the push that takes the remaining count to zero.
  assign last_pair = push && !continuous_q && (remaining_q == 33'd2);

  assign seed1 = seed_q[0];
  assign seed2 = seed_q[1];
  assign seed3 = seed_q[2];
  assign seed4 = seed_q[3];
  assign seed5 = seed_q[4];
  assign seed6 = seed_q[5];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    run_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_SEED;
          run_start = 1'b1;
        end
      end
      ST_SEED:  if (phase_cnt == 8'(RST_CYCLES - 1)) state_d = ST_WARM;
      ST_WARM:  if (phase_cnt == 8'(WARMUP - 1))     state_d = ST_RUN;
      ST_RUN:   if (stop || last_pair)               state_d = ST_DRAIN;
      // The output register counts as part of the buffer for draining.
      ST_DRAIN: if (fifo_empty && !out_valid)        state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Cycles spent in the current timed state; restarts on every transition.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_cnt <= '0;
    end else if (state_d != state_q) begin
      phase_cnt <= '0;
    end else if (state_q == ST_SEED || state_q == ST_WARM) begin
      phase_cnt <= phase_cnt + 8'd1;
    end
  end

  // ------------------------------------------------------ config registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SEEDS; i++) seed_q[i] <= default_seed(i);
      budget_q <= '0;
      cfg_err  <= 1'b0;
    end else begin
      if (run_start) begin
        cfg_err <= 1'b0;
      end else if (cfg_wr_ok && cfg_addr <= ADDR_SEED6 && cfg_wdata < SEED_MIN) begin
        cfg_err <= 1'b1;
      end
      if (cfg_wr_ok) begin
        if (cfg_addr == ADDR_BUDGET) begin
          budget_q <= cfg_wdata;
        end else if (cfg_addr <= ADDR_SEED6 && cfg_wdata >= SEED_MIN) begin
          for (int i = 0; i < NUM_SEEDS; i++) begin
            if (cfg_addr == ADDR_SEED1 + 3'(i)) seed_q[i] <= cfg_wdata;
          end
        end
      end
    end
  end

  // ------------------------------------------------------ run bookkeeping
  // remaining is one bit wider so an all-ones budget rounds up without wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      remaining_q  <= '0;
      continuous_q <= 1'b1;
      drop_cnt     <= '0;
    end else if (run_start) begin
      remaining_q  <= {1'b0, budget_q} + {32'd0, budget_q[0]};
      continuous_q <= (budget_q == '0);
      drop_cnt     <= '0;
    end else begin
      if (push && !continuous_q) remaining_q <= remaining_q - 33'd2;
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // ------------------------------------------------------ FIFO and output
  awgn_pair_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .flush  (run_start),
    .push   (push),
    .wdata0 (gen_x0),
    .wdata1 (gen_x1),
    .pop    (fifo_pop),
    .rdata  (fifo_rdata),
    .full2  (fifo_full2),
    .empty  (fifo_empty)
  );

  // Refill the output register whenever it is empty or being consumed, so
  // one sample per cycle flows with no bubble.
  assign fifo_pop = !fifo_empty && (!out_valid || out_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (run_start) begin
      out_valid <= 1'b0;
    end else if (fifo_pop) begin
      out_valid <= 1'b1;
      out_data  <= fifo_rdata;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_awgn_seq_ctrl.sv
// Directed-sequence bench for awgn_seq_ctrl with a random generator table and
// a scoreboard of expected output samples.
module tb_awgn_seq_ctrl;
  import awgn_pkg::*;

  localparam int DEPTH      = 8;
  localparam int RST_CYCLES = 4;
  localparam int WARMUP     = 3;
  localparam int TAB_N      = 4096;
  // Offset from the start-pulse cycle index to the table entry captured in
  // the first RUN cycle: start edge, SEED cycles, WARM cycles.
  localparam int RUN_OFS    = 1 + RST_CYCLES + WARMUP;

  // ------------------------------------------------ clock / reset / DUT
  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic        start, stop;
  logic        busy, cfg_err, gen_reset;
  logic [31:0] seed1, seed2, seed3, seed4, seed5, seed6;
  logic [15:0] gen_x0, gen_x1;
  logic [15:0] out_data;
  logic        out_valid, out_ready;
  logic [15:0] drop_cnt;
  logic [2:0]  state_dbg;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  awgn_seq_ctrl #(.DEPTH(DEPTH), .RST_CYCLES(RST_CYCLES), .WARMUP(WARMUP)) dut (
    .clk(clk), .reset(reset),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .start(start), .stop(stop),
    .busy(busy), .cfg_err(cfg_err), .gen_reset(gen_reset),
    .seed1(seed1), .seed2(seed2), .seed3(seed3),
    .seed4(seed4), .seed5(seed5), .seed6(seed6),
    .gen_x0(gen_x0), .gen_x1(gen_x1),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .drop_cnt(drop_cnt), .state_dbg(state_dbg)
  );

  // ------------------------------------------------ generator model
  // After edge k the generator presents tab[k]; the DUT samples it at k+1.
  logic [15:0] tab0 [TAB_N];
  logic [15:0] tab1 [TAB_N];

  initial begin
    for (int i = 0; i < TAB_N; i++) begin
      tab0[i] = 16'($urandom);
      tab1[i] = 16'($urandom);
    end
    gen_x0 = tab0[0];
    gen_x1 = tab1[0];
    forever begin
      @(posedge clk);
      #1;
      gen_x0 = tab0[cyc % TAB_N];
      gen_x1 = tab1[cyc % TAB_N];
    end
  end

  // ------------------------------------------------ scoreboard
  logic [15:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          first_valid_cyc = -1;
  logic        hold_pending = 1'b0;
  logic [15:0] hold_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected samples of npairs consecutive captures starting at table index base.
  task automatic queue_pairs(input int base, input int npairs);
    for (int j = 0; j < npairs; j++) begin
      exp_q.push_back(tab0[(base + j) % TAB_N]);
      exp_q.push_back(tab1[(base + j) % TAB_N]);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (hold_pending) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_data", out_data, hold_data);
      end
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && out_ready) begin
        check("sample_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) check("sample_data", out_data, exp_q.pop_front());
      end
      hold_pending = out_valid && !out_ready;
      hold_data    = out_data;
    end else begin
      hold_pending = 1'b0;
    end
  end

  // ------------------------------------------------ driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    tick();
    cfg_we    = 1'b0;
  endtask

  // Returns the cycle index c; the DUT samples start at edge c+1.
  task automatic start_run(output int c);
    c     = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (busy && n < max_cyc) begin
      tick();
      n++;
    end
    check(tag, busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------ directed sequence
  int c;
  int b;
  int np;
  int n;

  initial begin
    reset     = 1'b0;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_wdata = '0;
    start     = 1'b0;
    stop      = 1'b0;
    out_ready = 1'b0;
    repeat (3) tick();

    // Reset values
    check("rst_busy", busy, 1'b0);
    check("rst_cfg_err", cfg_err, 1'b0);
    check("rst_gen_reset", gen_reset, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 16'h0000);
    check("rst_drop_cnt", drop_cnt, 16'h0000);
    check("rst_seed1", seed1, 32'h0000_1234);
    check("rst_seed2", seed2, 32'h0000_5678);
    check("rst_seed3", seed3, 32'h0009_ABCD);
    check("rst_seed4", seed4, 32'h0000_4321);
    check("rst_seed5", seed5, 32'h0000_8765);
    check("rst_seed6", seed6, 32'h000D_CBA9);
    reset = 1'b1;
    tick();

    // Budget of 4 samples, downstream always ready
    out_ready = 1'b1;
    cfg_write(ADDR_BUDGET, 32'd4);
    first_valid_cyc = -1;
    start_run(c);
    queue_pairs(c + RUN_OFS, 2);
    check("b4_busy", busy, 1'b1);
    wait_until(c + RST_CYCLES);
    check("b4_gen_reset_seed", gen_reset, 1'b1);
    wait_until(c + RST_CYCLES + 1);
    check("b4_gen_reset_warm", gen_reset, 1'b0);
    wait_idle("b4_idle", 200);
    check("b4_all_samples", exp_q.size(), 0);
    check("b4_gen_reset_idle", gen_reset, 1'b1);
    check("b4_latency", (first_valid_cyc >= c + RUN_OFS + 1) &&
                        (first_valid_cyc <= c + RUN_OFS + 3), 1'b1);
    check("b4_drop_cnt", drop_cnt, 16'h0000);
    exp_q.delete();

    // Seed write rejection and boundary, cfg_err cleared by start
    cfg_write(3'd2, 32'd5);
    check("seed3_rejected", seed3, 32'h0009_ABCD);
    check("cfg_err_set", cfg_err, 1'b1);
    cfg_write(3'd1, 32'd16);
    check("seed2_min_ok", seed2, 32'd16);
    cfg_write(3'd1, 32'd15);
    check("seed2_15_rejected", seed2, 32'd16);
    cfg_write(3'd7, 32'd0);
    check("rsvd_seed1", seed1, 32'h0000_1234);
    cfg_write(ADDR_BUDGET, 32'd3);
    start_run(c);
    queue_pairs(c + RUN_OFS, 2);
    check("cfg_err_cleared", cfg_err, 1'b0);
    wait_idle("odd_budget_idle", 200);
    check("odd_budget_samples", exp_q.size(), 0);
    exp_q.delete();

    // Random small budgets with random backpressure (never enough to drop)
    for (int r = 0; r < 4; r++) begin
      b  = $urandom_range(1, 8);
      np = (b + 1) / 2;
      cfg_write(ADDR_BUDGET, 32'(b));
      start_run(c);
      queue_pairs(c + RUN_OFS, np);
      n = 0;
      while (busy && n < 400) begin
        out_ready = ($urandom_range(0, 3) != 0);
        tick();
        n++;
      end
      out_ready = 1'b1;
      check("rnd_idle", busy, 1'b0);
      check("rnd_samples", exp_q.size(), 0);
      check("rnd_drop_cnt", drop_cnt, 16'h0000);
      exp_q.delete();
    end

    // Continuous run with a stalled sink: FIFO fills, then drops accumulate
    cfg_write(ADDR_BUDGET, 32'd0);
    out_ready = 1'b0;
    start_run(c);
    queue_pairs(c + RUN_OFS, 4);
    wait_until(c + RUN_OFS + 12);
    check("drop_after_12", drop_cnt, 16'd8);
    wait_until(c + RUN_OFS + 20);
    check("drop_after_20", drop_cnt, 16'd16);
    check("stall_valid", out_valid, 1'b1);
    check("stall_head", out_data, tab0[(c + RUN_OFS) % TAB_N]);
    pulse_stop();
    out_ready = 1'b1;
    wait_idle("fill_idle", 200);
    check("fill_samples", exp_q.size(), 0);
    exp_q.delete();

    // Stop three cycles into RUN with the sink stalled
    out_ready = 1'b0;
    start_run(c);
    queue_pairs(c + RUN_OFS, 3);
    wait_until(c + RUN_OFS + 2);
    pulse_stop();
    repeat (5) tick();
    check("stop_drain_busy", busy, 1'b1);
    check("stop_drain_gen_reset", gen_reset, 1'b1);
    check("stop_no_drops", drop_cnt, 16'h0000);
    out_ready = 1'b1;
    wait_idle("stop_idle", 200);
    check("stop_pairs", (exp_q.size() == 0) || (exp_q.size() == 2), 1'b1);
    exp_q.delete();

    // Start during WARM and a seed write during RUN are both ignored
    cfg_write(ADDR_BUDGET, 32'd6);
    start_run(c);
    queue_pairs(c + RUN_OFS, 3);
    wait_until(c + RST_CYCLES + 2);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_until(c + RUN_OFS + 1);
    cfg_write(ADDR_SEED1, 32'hDEAD_0001);
    check("run_seed1_kept", seed1, 32'h0000_1234);
    wait_idle("ignore_idle", 200);
    check("ignore_samples", exp_q.size(), 0);
    exp_q.delete();

    // Asynchronous reset in the middle of a run
    cfg_write(ADDR_SEED1, 32'h0000_BEEF);
    check("seed1_written", seed1, 32'h0000_BEEF);
    cfg_write(ADDR_BUDGET, 32'd0);
    out_ready = 1'b0;
    start_run(c);
    wait_until(c + RUN_OFS + 10);
    check("pre_reset_drops", drop_cnt > 16'd0, 1'b1);
    reset = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_drop_cnt", drop_cnt, 16'h0000);
    check("mid_rst_seed1", seed1, 32'h0000_1234);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_gen_reset", gen_reset, 1'b1);
    exp_q.delete();
    tick();
    reset = 1'b1;
    tick();

    // Normal operation after reset
    out_ready = 1'b1;
    cfg_write(ADDR_BUDGET, 32'd2);
    start_run(c);
    queue_pairs(c + RUN_OFS, 1);
    wait_idle("post_rst_idle", 200);
    check("post_rst_samples", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
